// File: rtl/gen_fifo_async_rd_prefetch.sv
// Async FIFO read-side prefetch stage: credit-based pop, 2-entry skid, registered stream.
// Optional synchronous flush input under GEN_AFIFO_RD_PREFETCH_FLUSH_EN.
module gen_fifo_async_rd_prefetch #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  rclk,
  input  logic                  rreset,
  input  logic                  far_empty,
  input  logic                  far_dout_v,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
`ifdef GEN_AFIFO_RD_PREFETCH_FLUSH_EN
  input  logic                  flush,
`endif
  output logic                  pop,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            buf_level
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_nxt;
  logic [1:0]            r_occ;
  logic                  r_valid;

  logic                  w_flush;
  logic                  w_drain;
  logic [2:0]            w_sum;
  logic [1:0]            w_occ_nxt;
  logic                  w_to_head;
  logic                  w_shift;

`ifdef GEN_AFIFO_RD_PREFETCH_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_drain   = r_valid & m_ready;

  // drain implies occ >= 1, so this never underflows
  assign w_sum     = {1'b0, r_occ}
                   + {2'b00, far_dout_v}
                   - {2'b00, w_drain};
  assign w_occ_nxt = w_sum[1:0];

  assign pop = ~rreset & ~far_empty & ~w_flush
             & (w_sum < 3'd2);

  assign w_to_head = (r_occ == 2'd0)
                   | ((r_occ == 2'd1) & w_drain);
  assign w_shift   = w_drain & (r_occ == 2'd2);

  always_ff @(posedge rclk or posedge rreset) begin
    if (rreset) begin
      r_occ   <= 2'd0;
      r_valid <= 1'b0;
    end else if (w_flush) begin
      r_occ   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_valid <= (w_occ_nxt != 2'd0);
    end
  end

  always_ff @(posedge rclk or posedge rreset) begin
    if (rreset) begin
      r_head <= '0;
      r_nxt  <= '0;
    end else if (!w_flush) begin
      if (w_shift) begin
        r_head <= r_nxt;
        if (far_dout_v)
          r_nxt <= ram_rdata;
      end else if (far_dout_v) begin
        if (w_to_head)
          r_head <= ram_rdata;
        else
          r_nxt  <= ram_rdata;
      end
    end
  end

  assign m_valid   = r_valid;
  assign m_data    = r_head;
  assign buf_level = r_occ;

  // a word arriving into a full, stalled buffer means the credit rule was broken
  a_no_overflow : assert property (
    @(posedge rclk) disable iff (rreset)
    !(far_dout_v && (r_occ == 2'd2) && !w_drain && !w_flush)
  ) else $fatal(1, "prefetch buffer overflow");

endmodule

// File: tb/tb_gen_fifo_async_rd_prefetch.sv
// Bench for gen_fifo_async_rd_prefetch: controller/RAM model plus scoreboard monitor.
// Define GEN_AFIFO_RD_PREFETCH_FLUSH_EN to also cover the flush port.
module tb_gen_fifo_async_rd_prefetch;

  localparam int DW = 32;

  logic          rclk = 1'b0;
  logic          rreset;
  logic          far_empty;
  logic          far_dout_v;
  logic [DW-1:0] ram_rdata;
  logic          pop;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [1:0]    buf_level;
`ifdef GEN_AFIFO_RD_PREFETCH_FLUSH_EN
  logic          flush;
`endif

  logic [DW-1:0] mem [0:255];
  int            wr_ptr;
  int            rd_ptr;
  logic          inj;

  logic [DW-1:0] exp_q [$];
  int            checks;
  int            errors;
  int            cyc;
  int            acc_cnt;
  int            npop;
  int            lvl_max;

  always #5 rclk = ~rclk;

  gen_fifo_async_rd_prefetch #(.DATA_WIDTH(DW)) dut (
    .rclk       (rclk),
    .rreset     (rreset),
    .far_empty  (far_empty),
    .far_dout_v (far_dout_v),
    .ram_rdata  (ram_rdata),
`ifdef GEN_AFIFO_RD_PREFETCH_FLUSH_EN
    .flush      (flush),
`endif
    .pop        (pop),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .buf_level  (buf_level)
  );

  assign far_empty = (wr_ptr == rd_ptr);

  // read controller + RAM model: one-cycle read latency
  always @(posedge rclk or posedge rreset) begin
    if (rreset) begin
      far_dout_v <= 1'b0;
      rd_ptr     <= wr_ptr;
    end else if (pop || inj) begin
      far_dout_v <= 1'b1;
      ram_rdata  <= mem[rd_ptr[7:0]];
      rd_ptr     <= rd_ptr + 1;
    end else begin
      far_dout_v <= 1'b0;
    end
  end

  always @(posedge rclk) cyc <= cyc + 1;

  // scoreboard monitor
  always @(negedge rclk) begin
    logic [DW-1:0] e;
    if (pop) npop = npop + 1;
    if (int'(buf_level) > lvl_max) lvl_max = int'(buf_level);
    if (!rreset && m_valid && m_ready
`ifdef GEN_AFIFO_RD_PREFETCH_FLUSH_EN
        && !flush
`endif
       ) begin
      checks  = checks + 1;
      acc_cnt = acc_cnt + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb_unexpected: got %h, required no word", m_data);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e) begin
          errors = errors + 1;
          $display("FAIL sb_data: got %h, required %h", m_data, e);
        end
      end
    end
  end

  task automatic chk(string name, logic [DW-1:0] act,
                     logic [DW-1:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(logic [DW-1:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  task automatic wait_empty(string name, int bound);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      step();
      k++;
    end
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s: timeout, %0d words left, required 0",
               name, exp_q.size());
    end
  endtask

  task automatic wait_lvl2(string name);
    int k;
    k = 0;
    while (buf_level != 2'd2 && k < 20) begin
      step();
      k++;
    end
    chk(name, {30'd0, buf_level}, 32'd2);
  endtask

  initial begin
    int t0;
    int t1;
    int a0;
    int k;
    checks = 0; errors = 0; cyc = 0;
    acc_cnt = 0; npop = 0; lvl_max = 0;
    wr_ptr = 0; inj = 1'b0; ram_rdata = '0;
    m_ready = 1'b1;
    rreset = 1'b1;
`ifdef GEN_AFIFO_RD_PREFETCH_FLUSH_EN
    flush = 1'b0;
`endif
    #1;
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_level", {30'd0, buf_level}, 32'd0);
    chk("rst_pop", {31'd0, pop}, 32'd0);
    repeat (3) step();
    rreset = 1'b0;
    repeat (2) step();

    // first-word latency
    push(32'hA5A5_0001);
    #1;
    chk("lat_pop_T", {31'd0, pop}, 32'd1);
    step();
    chk("lat_valid_T1", {31'd0, m_valid}, 32'd0);
    step();
    chk("lat_valid_T2", {31'd0, m_valid}, 32'd1);
    chk("lat_data_T2", m_data, 32'hA5A5_0001);
    wait_empty("lat_drain", 10);

    // full-rate streaming
    lvl_max = 0;
    a0 = acc_cnt;
    for (int i = 0; i < 16; i++) push(i);
    t0 = -1; t1 = -1; k = 0;
    while (t1 < 0 && k < 60) begin
      step();
      k++;
      if (t0 < 0 && acc_cnt > a0) t0 = cyc;
      if (acc_cnt >= a0 + 16) t1 = cyc;
    end
    chk("stream_span", t1 - t0, 32'd15);
    chk("stream_lvl_le1", {31'd0, lvl_max <= 1}, 32'd1);
    wait_empty("stream_drain", 10);

    // back-pressure
    m_ready = 1'b0;
    npop = 0;
    for (int i = 0; i < 4; i++) push(32'hD000_0000 + i);
    repeat (5) step();
    chk("bp_data_mid", m_data, 32'hD000_0000);
    repeat (5) step();
    chk("bp_pops", npop, 32'd2);
    chk("bp_level", {30'd0, buf_level}, 32'd2);
    chk("bp_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_data_end", m_data, 32'hD000_0000);
    m_ready = 1'b1;
    #1;
    chk("bp_pop_resume", {31'd0, pop}, 32'd1);
    wait_empty("bp_drain", 20);

    // alternating ready
    for (int i = 0; i < 20; i++) push(32'hE000_0000 + i);
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      step();
      m_ready = ~m_ready;
      k++;
    end
    m_ready = 1'b1;
    wait_empty("toggle_drain", 10);

    // reset with a full buffer
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hC000_0000 + i);
    wait_lvl2("rst2_level_pre");
    rreset = 1'b1;
    #1;
    chk("rst2_valid", {31'd0, m_valid}, 32'd0);
    chk("rst2_level", {30'd0, buf_level}, 32'd0);
    chk("rst2_pop", {31'd0, pop}, 32'd0);
    exp_q.delete();
    step();
    chk("rst2_pop_hold", {31'd0, pop}, 32'd0);
    rreset = 1'b0;
    m_ready = 1'b1;
    repeat (2) step();
    push(32'h1234_5678);
    wait_empty("rst2_after", 10);

`ifdef GEN_AFIFO_RD_PREFETCH_FLUSH_EN
    // flush with a word in flight
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hB000_0000 + i);
    wait_lvl2("fl_level_pre");
    inj = 1'b1;
    step();
    inj = 1'b0;
    flush = 1'b1;
    #1;
    chk("fl_pop", {31'd0, pop}, 32'd0);
    chk("fl_dv", {31'd0, far_dout_v}, 32'd1);
    step();
    chk("fl_valid", {31'd0, m_valid}, 32'd0);
    chk("fl_level", {30'd0, buf_level}, 32'd0);
    for (int i = 0; i < 3; i++) void'(exp_q.pop_front());
    flush = 1'b0;
    m_ready = 1'b1;
    wait_empty("fl_drain", 10);
`endif

    repeat (3) step();
    chk("final_queue", exp_q.size(), 32'd0);
    chk("final_valid", {31'd0, m_valid}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit, required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gen_fifo_async_rd_prefetch.md
# gen_fifo_async_rd_prefetch

Read-side output stage for the asynchronous FIFO, in the rclk domain directly downstream of the read controller. It issues pops against the controller's empty flag and absorbs the one-cycle RAM read latency (data valid with `far_dout_v`) in a 2-entry prefetch buffer. It presents the data on a registered valid/ready stream that sustains one word per cycle.

## Interface
- `DATA_WIDTH`, default 32: RAM read data / stream width.
- `rclk`  in  1  read clock; all logic on its rising edge.
- `rreset`  in  1  asynchronous, active-high reset.
- `far_empty`  in  1  FIFO empty as seen in the read domain, from the read controller.
- `far_dout_v`  in  1  RAM read data valid this cycle (registered pop of the previous cycle).
- `ram_rdata`  in  DATA_WIDTH  RAM read data; qualified by `far_dout_v`.
- `pop`  out  1  read request to the read controller; combinational.
- `m_valid`  out  1  stream data valid; registered.
- `m_data`  out  DATA_WIDTH  stream data; registered.
- `m_ready`  in  1  downstream accept.
- `buf_level`  out  2  entries held in the prefetch buffer (0..2); registered.
- `flush`  in  1  present only with `GEN_AFIFO_RD_PREFETCH_FLUSH_EN` (see Configuration).

## Operation
- Storage:
  - head register drives `m_data`.
  - second register `nxt`.
  - occupancy `occ` (0..2); `buf_level = occ`; `m_valid = (occ != 0)`.
- Drain: `drain = m_valid & m_ready`.
- Pop rule: `pop = ~far_empty & ((occ + far_dout_v - drain) < 2)`.
  - Compute the sum in 3 bits, unsigned; it never goes negative, because drain implies occ ≥ 1.
  - `pop` is never asserted while `far_empty` = 1, so the controller's internal gating is a no-op.
- Write on `far_dout_v`:
  - To head if `occ == 0`, or if `occ == 1` and `drain`.
  - Otherwise to `nxt`.
- Drain with `occ == 2`: `nxt` moves to head in the same edge. A simultaneous `far_dout_v` writes `nxt`.
- Occupancy update: `occ_next = occ + far_dout_v - drain`.
- Credit guarantee: the pop rule guarantees `occ_next` ≤ 2, so overflow is structurally impossible. Assert in simulation: `far_dout_v` while `occ == 2` and not `drain` is a fatal error.
- Ordering: words leave in strictly the order `ram_rdata` arrived. There is no reordering and no duplication.
- Stalls: while `m_ready` = 0, `m_data` and `m_valid` hold stable.

## Timing
- Reset values: `pop` = 0 (combinational, forced by reset), `m_valid` = 0, `m_data` = 0, `buf_level` = 0, `occ` = 0, `nxt` = 0.
- First-word latency: `far_empty` falls in cycle T → `pop` in T → `far_dout_v` in T+1 → `m_valid` = 1 in T+2.
- Throughput: with `m_ready` held high and the FIFO non-empty, steady state is `occ` = 1 with one read in flight, giving one word per cycle with no bubbles.
- Back-pressure: with `m_ready` = 0, at most 2 words are fetched (`occ` → 2) and then `pop` stays 0. On `m_ready` rising, `pop` resumes in the same cycle as the first drain, because `occ + inflight - drain` = 1.
- FIFO goes empty mid-stream: buffered words continue to drain. `m_valid` falls the cycle after the last word is accepted.
- Reset mid-operation: buffer contents are lost, and `m_valid` falls asynchronously. The read controller is reset by the same `rreset`, so any in-flight word is discarded on both sides.

## Configuration
- `GEN_AFIFO_RD_PREFETCH_FLUSH_EN` defined: adds the `flush` input (1 bit, synchronous, active-high).
  - In a cycle with `flush` = 1: `pop` is forced to 0.
  - Next edge: `occ` → 0, `m_valid` → 0, `buf_level` → 0.
  - Any `far_dout_v` in the flush cycle is discarded.
  - `drain` is ignored; downstream must not count a handshake in the flush cycle.
  - Words still in the FIFO RAM are unaffected; fetching restarts the cycle after `flush` deasserts.
- Not defined: no `flush` port; flush logic is absent; behaviour is as above with flush tied 0.

## Test plan
- Reset, then `far_empty` = 0 with `ram_rdata` = 0xA5A5_0001 on the first `far_dout_v`, `m_ready` = 1 → `pop` in cycle 0, `m_valid` = 1 with `m_data` = 0xA5A5_0001 in cycle 2.
- 16 words 0x0..0xF streamed with `m_ready` = 1 → 16 consecutive accept cycles with data 0x0..0xF in order, `buf_level` ≤ 1 throughout.
- `m_ready` = 0 for 10 cycles with the FIFO non-empty → exactly 2 pops, `buf_level` = 2, `m_data` stable. Then `m_ready` = 1 → `pop` reasserts in the same cycle and no word is lost or duplicated.
- `m_ready` toggling 1/0 every cycle over 20 words → output sequence matches input sequence, and the overflow assertion never fires.
- `rreset` pulsed while `buf_level` = 2 → `m_valid`/`buf_level` = 0 immediately, and `pop` = 0 while reset is high.
- (`GEN_AFIFO_RD_PREFETCH_FLUSH_EN`) `flush` pulsed with `buf_level` = 2 and `far_dout_v` = 1 → next cycle `m_valid` = 0, `buf_level` = 0, and the in-flight word is not emitted. The next emitted word is the following FIFO entry.
